// File: rtl/cpu_pkg.sv
// ============================================================================
// cpu_pkg : shared opcode constants, instruction width and fetch FSM states
// Rev 1.0
// ============================================================================
`default_nettype none

package cpu_pkg;

  localparam int INSTR_W = 32;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic [0:0] {
    REQ  = 1'b0,
    FULL = 1'b1
  } fetch_state_t;

  // Primary opcode field of a MIPS word.
  function automatic logic [5:0] instr_opcode(input logic [INSTR_W-1:0] instr);
    return instr[31:26];
  endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_stage_if.sv
// ============================================================================
// fetch_stage_if : instruction-memory req/ready handshake between fetch and imem
// Rev 1.0
// ============================================================================
`default_nettype none

interface fetch_stage_if #(
  parameter int ADDR_W  = 32,
  parameter int INSTR_W = 32
);

  logic               imem_req;
  logic [ADDR_W-1:0]  imem_addr;
  logic               imem_ready;
  logic [INSTR_W-1:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rdata
  );

endinterface

`default_nettype wire

// File: rtl/fetch_skid_buf.sv
// ============================================================================
// fetch_skid_buf : one-entry holding register for a word returned during stall
// Rev 1.0
// ============================================================================
`default_nettype none

module fetch_skid_buf
  import cpu_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int INSTR_W = 32
) (
  input  wire logic               clk,
  input  wire logic               reset,
  input  wire logic               load,
  input  wire logic               drain,
  input  wire logic               flush,
  input  wire logic [INSTR_W-1:0] in_instr,
  input  wire logic [ADDR_W-1:0]  in_pc,
  output logic                    valid,
  output logic [INSTR_W-1:0]      instr,
  output logic [ADDR_W-1:0]       pc
);

  // Flush beats load: a redirect must never leave a stale word behind.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      valid <= 1'b0;
      instr <= INSTR_W'(NOP_INSTR);
      pc    <= '0;
    end else if (load) begin
      valid <= 1'b1;
      instr <= in_instr;
      pc    <= in_pc;
    end else if (drain) begin
      valid <= 1'b0;
      instr <= INSTR_W'(NOP_INSTR);
    end
  end

endmodule

`default_nettype wire

// File: rtl/fetch_stage.sv
// ============================================================================
// fetch_stage : PC, imem request, skid-protected output register to decoder.
// Optional macro FETCH_ALIGN_CHECK_EN: word-align redirects, sticky misalign_err.
// Rev 1.0
// ============================================================================
`default_nettype none

module fetch_stage
  import cpu_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000,
  parameter int                INSTR_W  = 32
) (
  input  wire logic               clk,
  input  wire logic               reset,
  fetch_stage_if.master           imem,
  input  wire logic               stall,
  input  wire logic               redirect,
  input  wire logic [ADDR_W-1:0]  redirect_pc,
  output logic                    out_valid,
  output logic [INSTR_W-1:0]      out_instr,
  output logic [ADDR_W-1:0]       out_pc,
  output logic [ADDR_W-1:0]       out_pc_plus4,
  output logic [5:0]              opcode,
  output logic [5:0]              funct,
  output logic [4:0]              rs,
  output logic [4:0]              rt,
  output logic [4:0]              rd,
  output logic [15:0]             imm,
  output logic                    misalign_err
);

  localparam logic [ADDR_W-1:0] C_PC_STEP = ADDR_W'(4);

  fetch_state_t       r_state;
  logic [ADDR_W-1:0]  r_pc;
  logic [ADDR_W-1:0]  w_redirect_target;

  logic               w_skid_load;
  logic               w_skid_drain;
  logic               w_skid_valid;
  logic [INSTR_W-1:0] w_skid_instr;
  logic [ADDR_W-1:0]  w_skid_pc;

  assign imem.imem_req  = (r_state == REQ) && !reset;
  assign imem.imem_addr = r_pc;

  // Word arrives while the output register is occupied and held.
  assign w_skid_load  = !redirect && (r_state == REQ) && imem.imem_ready && out_valid && stall;
  assign w_skid_drain = !redirect && (r_state == FULL) && !stall;

`ifdef FETCH_ALIGN_CHECK_EN
  logic r_misalign;

  assign w_redirect_target = {redirect_pc[ADDR_W-1:2], 2'b00};
  assign misalign_err      = r_misalign;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_misalign <= 1'b0;
    end else if (redirect && (redirect_pc[1:0] != 2'b00)) begin
      r_misalign <= 1'b1;
    end
  end
`else
  assign w_redirect_target = redirect_pc;
  assign misalign_err      = 1'b0;
`endif

  fetch_skid_buf #(
    .ADDR_W  (ADDR_W),
    .INSTR_W (INSTR_W)
  ) u_skid (
    .clk      (clk),
    .reset    (reset),
    .load     (w_skid_load),
    .drain    (w_skid_drain),
    .flush    (redirect),
    .in_instr (imem.imem_rdata),
    .in_pc    (r_pc),
    .valid    (w_skid_valid),
    .instr    (w_skid_instr),
    .pc       (w_skid_pc)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= REQ;
      r_pc         <= RESET_PC;
      out_valid    <= 1'b0;
      out_instr    <= INSTR_W'(NOP_INSTR);
      out_pc       <= '0;
      out_pc_plus4 <= '0;
    end else if (redirect) begin
      // Any word returned this cycle belongs to the abandoned path.
      r_state   <= REQ;
      r_pc      <= w_redirect_target;
      out_valid <= 1'b0;
      out_instr <= INSTR_W'(NOP_INSTR);
    end else begin
      case (r_state)
        REQ: begin
          if (imem.imem_ready) begin
            r_pc <= r_pc + C_PC_STEP;
            if (!out_valid || !stall) begin
              out_valid    <= 1'b1;
              out_instr    <= imem.imem_rdata;
              out_pc       <= r_pc;
              out_pc_plus4 <= r_pc + C_PC_STEP;
            end else begin
              r_state <= FULL;
            end
          end else if (out_valid && !stall) begin
            out_valid <= 1'b0;
            out_instr <= INSTR_W'(NOP_INSTR);
          end
        end
        FULL: begin
          if (!stall) begin
            out_valid    <= w_skid_valid;
            out_instr    <= w_skid_instr;
            out_pc       <= w_skid_pc;
            out_pc_plus4 <= w_skid_pc + C_PC_STEP;
            r_state      <= REQ;
          end
        end
        default: r_state <= REQ;
      endcase
    end
  end

  // Decode fields are plain slices; a bubble carries NOP so they read zero.
  assign opcode = instr_opcode(out_instr);
  assign funct  = out_instr[5:0];
  assign rs     = out_instr[25:21];
  assign rt     = out_instr[20:16];
  assign rd     = out_instr[15:11];
  assign imm    = out_instr[15:0];

endmodule

`default_nettype wire
